// File: rtl/dm_cmd_pkg.sv
// Shared encodings for the DataMover command/status engine: op codes, status
// bit positions, command word field offsets and the command word builder.
package dm_cmd_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } dm_op_e;

    // DataMover status byte: {OKAY, SLVERR, DECERR, INTERR, tag[3:0]}
    localparam int unsigned STS_OKAY_BIT   = 7;
    localparam int unsigned STS_SLVERR_BIT = 6;
    localparam int unsigned STS_DECERR_BIT = 5;
    localparam int unsigned STS_INTERR_BIT = 4;
    localparam int unsigned STS_ERR_LSB    = STS_INTERR_BIT;
    localparam logic [2:0]  ERR_INTERR     = 3'b001;

    localparam int unsigned CMD_BTT_LSB  = 0;
    localparam int unsigned CMD_TYPE_BIT = 23;
    localparam int unsigned CMD_DSA_LSB  = 24;
    localparam int unsigned CMD_EOF_BIT  = 30;
    localparam int unsigned CMD_DRR_BIT  = 31;
    localparam int unsigned CMD_ADDR_LSB = 32;

    localparam int unsigned CMD_BTT_MAX  = 23;
    localparam int unsigned CMD_ADDR_MAX = 64;
    localparam int unsigned CMD_MAX_W    = CMD_ADDR_MAX + 40;

    // Built at the widest layout; the tag lands directly above addr_w address bits.
    function automatic logic [CMD_MAX_W-1:0] build_cmd(
        input logic [CMD_ADDR_MAX-1:0] addr,
        input logic [CMD_BTT_MAX-1:0]  btt,
        input logic [3:0]              tag,
        input int unsigned             addr_w
    );
        logic [CMD_MAX_W-1:0]    cmd;
        logic [CMD_ADDR_MAX-1:0] addr_mask;
        addr_mask = (addr_w >= CMD_ADDR_MAX) ? '1
                  : ((CMD_ADDR_MAX'(1) << addr_w) - CMD_ADDR_MAX'(1));
        cmd = '0;
        cmd[CMD_BTT_LSB +: CMD_BTT_MAX] = btt;
        cmd[CMD_TYPE_BIT]               = 1'b1;
        cmd[CMD_DSA_LSB +: 6]           = '0;
        cmd[CMD_EOF_BIT]                = 1'b1;
        cmd[CMD_DRR_BIT]                = 1'b0;
        cmd = cmd | (CMD_MAX_W'(addr & addr_mask) << CMD_ADDR_LSB);
        cmd = cmd | (CMD_MAX_W'(tag) << (CMD_ADDR_LSB + addr_w));
        return cmd;
    endfunction

endpackage

// File: rtl/dm_tag_table.sv
// Outstanding-request table: per-slot pending flags and merged error, status
// beat matching, and strictly in-order retire from the head tag.
module dm_tag_table
    import dm_cmd_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BTT_WIDTH       = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_en,
    input  logic [3:0]           alloc_tag,
    input  logic [1:0]           alloc_op,
    input  logic [BTT_WIDTH-1:0] alloc_btt,
    input  logic                 alloc_pend_mm2s,
    input  logic                 alloc_pend_s2mm,
    input  logic [2:0]           alloc_err,
    input  logic                 mm2s_sts_valid,
    input  logic [7:0]           mm2s_sts,
    input  logic                 s2mm_sts_valid,
    input  logic [7:0]           s2mm_sts,
    input  logic                 retire,
    output logic                 head_valid,
    output logic [3:0]           head_tag,
    output logic [BTT_WIDTH-1:0] head_btt,
    output logic [2:0]           head_err,
    output logic                 mm2s_bad,
    output logic                 s2mm_bad
);

    localparam int unsigned IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [MAX_OUTSTANDING-1:0] valid_q, valid_d;
    logic [MAX_OUTSTANDING-1:0] pend_mm2s_q, pend_mm2s_d;
    logic [MAX_OUTSTANDING-1:0] pend_s2mm_q, pend_s2mm_d;
    logic [2:0]                 err_q [MAX_OUTSTANDING];
    logic [2:0]                 err_d [MAX_OUTSTANDING];
    logic [BTT_WIDTH-1:0]       btt_q [MAX_OUTSTANDING];
    logic [BTT_WIDTH-1:0]       btt_d [MAX_OUTSTANDING];
    logic [1:0]                 op_q  [MAX_OUTSTANDING];
    logic [1:0]                 op_d  [MAX_OUTSTANDING];
    logic [3:0]                 head_tag_q, head_tag_d;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] mm2s_idx;
    logic [IDX_W-1:0] s2mm_idx;
    logic             unused_bits;

    assign head_idx  = head_tag_q[IDX_W-1:0];
    assign alloc_idx = alloc_tag[IDX_W-1:0];
    assign mm2s_idx  = mm2s_sts[IDX_W-1:0];
    assign s2mm_idx  = s2mm_sts[IDX_W-1:0];
    assign unused_bits = ^{alloc_tag, mm2s_sts, s2mm_sts};

    assign head_valid = valid_q[head_idx] && !pend_mm2s_q[head_idx] && !pend_s2mm_q[head_idx];
    assign head_tag   = head_tag_q;
    assign head_btt   = btt_q[head_idx];
    assign head_err   = err_q[head_idx];

    always_comb begin
        valid_d     = valid_q;
        pend_mm2s_d = pend_mm2s_q;
        pend_s2mm_d = pend_s2mm_q;
        err_d       = err_q;
        btt_d       = btt_q;
        op_d        = op_q;
        head_tag_d  = head_tag_q;
        mm2s_bad    = 1'b0;
        s2mm_bad    = 1'b0;

        if (retire) begin
            valid_d[head_idx] = 1'b0;
            head_tag_d        = head_tag_q + 4'd1;
        end

        if (alloc_en) begin
            valid_d[alloc_idx]     = 1'b1;
            pend_mm2s_d[alloc_idx] = alloc_pend_mm2s;
            pend_s2mm_d[alloc_idx] = alloc_pend_s2mm;
            err_d[alloc_idx]       = alloc_err;
            btt_d[alloc_idx]       = alloc_btt;
            op_d[alloc_idx]        = alloc_op;
        end

        // Both streams OR into err_d so same-cycle beats to one slot both land.
        if (mm2s_sts_valid) begin
            if (valid_q[mm2s_idx] && pend_mm2s_q[mm2s_idx]) begin
                pend_mm2s_d[mm2s_idx] = 1'b0;
                err_d[mm2s_idx] = err_d[mm2s_idx] | mm2s_sts[STS_ERR_LSB +: 3];
            end else begin
                mm2s_bad = 1'b1;
            end
        end

        if (s2mm_sts_valid) begin
            if (valid_q[s2mm_idx] && pend_s2mm_q[s2mm_idx]) begin
                pend_s2mm_d[s2mm_idx] = 1'b0;
                err_d[s2mm_idx] = err_d[s2mm_idx] | s2mm_sts[STS_ERR_LSB +: 3];
            end else begin
                s2mm_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            pend_mm2s_q <= '0;
            pend_s2mm_q <= '0;
            head_tag_q  <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                err_q[i] <= '0;
                btt_q[i] <= '0;
                op_q[i]  <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            pend_mm2s_q <= pend_mm2s_d;
            pend_s2mm_q <= pend_s2mm_d;
            head_tag_q  <= head_tag_d;
            err_q       <= err_d;
            btt_q       <= btt_d;
            op_q        <= op_d;
        end
    end

endmodule

// File: rtl/dm_cmd_sts_engine.sv
// DataMover command/status engine: accepts READ/WRITE/COPY requests, issues
// tagged MM2S/S2MM commands, and retires requests in order with counters.
module dm_cmd_sts_engine
    import dm_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned BTT_WIDTH       = 23,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_saddr,
    input  logic [ADDR_WIDTH-1:0]   req_daddr,
    input  logic [BTT_WIDTH-1:0]    req_btt,
    output logic [3:0]              req_tag,
    output logic [ADDR_WIDTH+39:0]  m_axis_mm2s_cmd_tdata,
    output logic                    m_axis_mm2s_cmd_tvalid,
    input  logic                    m_axis_mm2s_cmd_tready,
    output logic [ADDR_WIDTH+39:0]  m_axis_s2mm_cmd_tdata,
    output logic                    m_axis_s2mm_cmd_tvalid,
    input  logic                    m_axis_s2mm_cmd_tready,
    input  logic [7:0]              s_axis_mm2s_sts_tdata,
    input  logic                    s_axis_mm2s_sts_tvalid,
    output logic                    s_axis_mm2s_sts_tready,
    input  logic [7:0]              s_axis_s2mm_sts_tdata,
    input  logic                    s_axis_s2mm_sts_tvalid,
    output logic                    s_axis_s2mm_sts_tready,
    output logic                    cmpl_valid,
    input  logic                    cmpl_ready,
    output logic [3:0]              cmpl_tag,
    output logic [3:0]              cmpl_status,
    output logic [4:0]              outstanding,
    output logic [63:0]             bytes_done,
    output logic [31:0]             cmds_done,
    output logic                    tag_err
);

    localparam int unsigned CMD_W = ADDR_WIDTH + 40;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e           state_q, state_d;
    logic             mm2s_tvalid_q, mm2s_tvalid_d;
    logic             s2mm_tvalid_q, s2mm_tvalid_d;
    logic [CMD_W-1:0] mm2s_cmd_q, mm2s_cmd_d;
    logic [CMD_W-1:0] s2mm_cmd_q, s2mm_cmd_d;
    logic [3:0]       tag_q, tag_d;
    logic [4:0]       outstanding_q, outstanding_d;
    logic [63:0]      bytes_q, bytes_d;
    logic [31:0]      cmds_q, cmds_d;
    logic             tag_err_q, tag_err_d;
    logic             sts_rdy_q, sts_rdy_d;

    dm_op_e               op;
    logic                 accept;
    logic                 legal;
    logic                 need_mm2s;
    logic                 need_s2mm;
    logic                 retire;
    logic                 head_valid;
    logic [3:0]           head_tag;
    logic [BTT_WIDTH-1:0] head_btt;
    logic [2:0]           head_err;
    logic                 mm2s_bad;
    logic                 s2mm_bad;

    assign op        = dm_op_e'(req_op);
    assign req_ready = (state_q == IDLE) && (outstanding_q < 5'(MAX_OUTSTANDING));
    assign accept    = req_valid && req_ready;
    assign legal     = (op != OP_RSVD) && (req_btt != '0);
    assign need_mm2s = legal && ((op == OP_READ) || (op == OP_COPY));
    assign need_s2mm = legal && ((op == OP_WRITE) || (op == OP_COPY));
    assign retire    = head_valid && cmpl_ready;

    always_comb begin
        state_d       = state_q;
        mm2s_tvalid_d = mm2s_tvalid_q;
        s2mm_tvalid_d = s2mm_tvalid_q;
        mm2s_cmd_d    = mm2s_cmd_q;
        s2mm_cmd_d    = s2mm_cmd_q;
        case (state_q)
            IDLE: begin
                // Illegal requests are accepted but issue nothing, so the FSM stays here.
                if (accept && legal) begin
                    mm2s_tvalid_d = need_mm2s;
                    s2mm_tvalid_d = need_s2mm;
                    mm2s_cmd_d    = CMD_W'(build_cmd(CMD_ADDR_MAX'(req_saddr),
                                                     CMD_BTT_MAX'(req_btt), tag_q, ADDR_WIDTH));
                    s2mm_cmd_d    = CMD_W'(build_cmd(CMD_ADDR_MAX'(req_daddr),
                                                     CMD_BTT_MAX'(req_btt), tag_q, ADDR_WIDTH));
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (m_axis_mm2s_cmd_tready) mm2s_tvalid_d = 1'b0;
                if (m_axis_s2mm_cmd_tready) s2mm_tvalid_d = 1'b0;
                if (!mm2s_tvalid_d && !s2mm_tvalid_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_d         = accept ? tag_q + 4'd1 : tag_q;
        outstanding_d = outstanding_q;
        case ({accept, retire})
            2'b10:   outstanding_d = outstanding_q + 5'd1;
            2'b01:   outstanding_d = outstanding_q - 5'd1;
            default: outstanding_d = outstanding_q;
        endcase
        bytes_d = bytes_q;
        cmds_d  = cmds_q;
        if (retire) begin
            cmds_d = cmds_q + 32'd1;
            if (head_err == 3'b000) bytes_d = bytes_q + 64'(head_btt);
        end
        tag_err_d = tag_err_q || mm2s_bad || s2mm_bad;
        sts_rdy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mm2s_tvalid_q <= 1'b0;
            s2mm_tvalid_q <= 1'b0;
            mm2s_cmd_q    <= '0;
            s2mm_cmd_q    <= '0;
            tag_q         <= '0;
            outstanding_q <= '0;
            bytes_q       <= '0;
            cmds_q        <= '0;
            tag_err_q     <= 1'b0;
            sts_rdy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mm2s_tvalid_q <= mm2s_tvalid_d;
            s2mm_tvalid_q <= s2mm_tvalid_d;
            mm2s_cmd_q    <= mm2s_cmd_d;
            s2mm_cmd_q    <= s2mm_cmd_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            bytes_q       <= bytes_d;
            cmds_q        <= cmds_d;
            tag_err_q     <= tag_err_d;
            sts_rdy_q     <= sts_rdy_d;
        end
    end

    dm_tag_table #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .BTT_WIDTH       (BTT_WIDTH)
    ) u_tag_table (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_en        (accept),
        .alloc_tag       (tag_q),
        .alloc_op        (req_op),
        .alloc_btt       (req_btt),
        .alloc_pend_mm2s (need_mm2s),
        .alloc_pend_s2mm (need_s2mm),
        .alloc_err       (legal ? 3'b000 : ERR_INTERR),
        .mm2s_sts_valid  (s_axis_mm2s_sts_tvalid && sts_rdy_q),
        .mm2s_sts        (s_axis_mm2s_sts_tdata),
        .s2mm_sts_valid  (s_axis_s2mm_sts_tvalid && sts_rdy_q),
        .s2mm_sts        (s_axis_s2mm_sts_tdata),
        .retire          (retire),
        .head_valid      (head_valid),
        .head_tag        (head_tag),
        .head_btt        (head_btt),
        .head_err        (head_err),
        .mm2s_bad        (mm2s_bad),
        .s2mm_bad        (s2mm_bad)
    );

    assign req_tag                = tag_q;
    assign m_axis_mm2s_cmd_tdata  = mm2s_cmd_q;
    assign m_axis_mm2s_cmd_tvalid = mm2s_tvalid_q;
    assign m_axis_s2mm_cmd_tdata  = s2mm_cmd_q;
    assign m_axis_s2mm_cmd_tvalid = s2mm_tvalid_q;
    assign s_axis_mm2s_sts_tready = sts_rdy_q;
    assign s_axis_s2mm_sts_tready = sts_rdy_q;
    assign cmpl_valid             = head_valid;
    assign cmpl_tag               = head_tag;
    assign cmpl_status            = {head_err == 3'b000, head_err};
    assign outstanding            = outstanding_q;
    assign bytes_done             = bytes_q;
    assign cmds_done              = cmds_q;
    assign tag_err                = tag_err_q;

endmodule

// File: tb/tb_dm_cmd_sts_engine.sv
// Scoreboard bench for dm_cmd_sts_engine: stimulus pushes expected commands and
// completions; negedge monitors pop and compare on every DUT handshake.
module tb_dm_cmd_sts_engine;

    localparam int unsigned AW  = 32;
    localparam int unsigned BW  = 23;
    localparam int unsigned MO  = 4;
    localparam int unsigned CW  = AW + 40;

    typedef struct packed {
        logic [3:0]  tag;
        logic [3:0]  status;
        logic [22:0] btt;
    } cmpl_exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_saddr = '0;
    logic [AW-1:0] req_daddr = '0;
    logic [BW-1:0] req_btt = '0;
    logic [3:0]    req_tag;
    logic [CW-1:0] mm2s_tdata, s2mm_tdata;
    logic          mm2s_tvalid, s2mm_tvalid;
    logic          mm2s_tready = 1'b1;
    logic          s2mm_tready = 1'b1;
    logic [7:0]    mm2s_sts = '0;
    logic [7:0]    s2mm_sts = '0;
    logic          mm2s_sts_valid = 1'b0;
    logic          s2mm_sts_valid = 1'b0;
    logic          mm2s_sts_ready, s2mm_sts_ready;
    logic          cmpl_valid;
    logic          cmpl_ready = 1'b1;
    logic [3:0]    cmpl_tag, cmpl_status;
    logic [4:0]    outstanding;
    logic [63:0]   bytes_done;
    logic [31:0]   cmds_done;
    logic          tag_err;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [127:0]  q_mm2s [$];
    logic [127:0]  q_s2mm [$];
    cmpl_exp_t     q_cmpl [$];
    logic [63:0]   m_bytes = '0;
    logic [31:0]   m_cmds = '0;

    always #5 clk = ~clk;

    dm_cmd_sts_engine #(
        .ADDR_WIDTH      (AW),
        .BTT_WIDTH       (BW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_op                 (req_op),
        .req_saddr              (req_saddr),
        .req_daddr              (req_daddr),
        .req_btt                (req_btt),
        .req_tag                (req_tag),
        .m_axis_mm2s_cmd_tdata  (mm2s_tdata),
        .m_axis_mm2s_cmd_tvalid (mm2s_tvalid),
        .m_axis_mm2s_cmd_tready (mm2s_tready),
        .m_axis_s2mm_cmd_tdata  (s2mm_tdata),
        .m_axis_s2mm_cmd_tvalid (s2mm_tvalid),
        .m_axis_s2mm_cmd_tready (s2mm_tready),
        .s_axis_mm2s_sts_tdata  (mm2s_sts),
        .s_axis_mm2s_sts_tvalid (mm2s_sts_valid),
        .s_axis_mm2s_sts_tready (mm2s_sts_ready),
        .s_axis_s2mm_sts_tdata  (s2mm_sts),
        .s_axis_s2mm_sts_tvalid (s2mm_sts_valid),
        .s_axis_s2mm_sts_tready (s2mm_sts_ready),
        .cmpl_valid             (cmpl_valid),
        .cmpl_ready             (cmpl_ready),
        .cmpl_tag               (cmpl_tag),
        .cmpl_status            (cmpl_status),
        .outstanding            (outstanding),
        .bytes_done             (bytes_done),
        .cmds_done              (cmds_done),
        .tag_err                (tag_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: condition not met", name);
    endtask

    // {pad, tag, addr, DRR=0, EOF=1, DSA=0, TYPE=1, BTT}
    function automatic logic [127:0] exp_cmd(input logic [31:0] addr, input logic [22:0] btt,
                                             input logic [3:0] tag);
        return {56'h0, 4'h0, tag, addr, 1'b0, 1'b1, 6'b000000, 1'b1, btt};
    endfunction

    always @(negedge clk) begin
        if (rst_n && mm2s_tvalid && mm2s_tready) begin
            if (q_mm2s.size() == 0) fail_now("mm2s_unexpected_cmd");
            else chk("mm2s_cmd", 128'(mm2s_tdata), q_mm2s.pop_front());
        end
        if (rst_n && s2mm_tvalid && s2mm_tready) begin
            if (q_s2mm.size() == 0) fail_now("s2mm_unexpected_cmd");
            else chk("s2mm_cmd", 128'(s2mm_tdata), q_s2mm.pop_front());
        end
    end

    always @(negedge clk) begin
        cmpl_exp_t e;
        if (rst_n && cmpl_valid && cmpl_ready) begin
            if (q_cmpl.size() == 0) begin
                fail_now("cmpl_unexpected");
            end else begin
                e = q_cmpl.pop_front();
                chk("cmpl_tag", 128'(cmpl_tag), 128'(e.tag));
                chk("cmpl_status", 128'(cmpl_status), 128'(e.status));
                chk("bytes_before_retire", 128'(bytes_done), 128'(m_bytes));
                chk("cmds_before_retire", 128'(cmds_done), 128'(m_cmds));
                m_cmds = m_cmds + 32'd1;
                if (e.status == 4'h8) m_bytes = m_bytes + 64'(e.btt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [31:0] sa, input logic [31:0] da,
                            input logic [22:0] btt, input logic [3:0] tag);
        int unsigned n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) fail_now("req_ready_timeout");
        req_valid = 1'b1;
        req_op    = op;
        req_saddr = sa;
        req_daddr = da;
        req_btt   = btt;
        chk("req_tag", 128'(req_tag), 128'(tag));
        if (op != 2'b11 && btt != 0) begin
            if (op == 2'b00 || op == 2'b10) q_mm2s.push_back(exp_cmd(sa, btt, tag));
            if (op == 2'b01 || op == 2'b10) q_s2mm.push_back(exp_cmd(da, btt, tag));
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic exp_cmpl(input logic [3:0] tag, input logic [3:0] st, input logic [22:0] btt);
        cmpl_exp_t e;
        e.tag = tag;
        e.status = st;
        e.btt = btt;
        q_cmpl.push_back(e);
    endtask

    task automatic send_sts(input bit s2mm, input logic [7:0] d);
        if (s2mm) begin
            s2mm_sts = d;
            s2mm_sts_valid = 1'b1;
        end else begin
            mm2s_sts = d;
            mm2s_sts_valid = 1'b1;
        end
        tick();
        mm2s_sts_valid = 1'b0;
        s2mm_sts_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((q_mm2s.size() != 0 || q_s2mm.size() != 0 || q_cmpl.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_mm2s_tvalid", 128'(mm2s_tvalid), 128'(0));
        chk("rst_s2mm_tvalid", 128'(s2mm_tvalid), 128'(0));
        chk("rst_cmpl_valid", 128'(cmpl_valid), 128'(0));
        chk("rst_sts_tready", 128'({mm2s_sts_ready, s2mm_sts_ready}), 128'(0));
        rst_n = 1'b1;
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_counters", 128'({outstanding, bytes_done, cmds_done, tag_err}), 128'(0));
        tick();
        chk("sts_tready_up", 128'({mm2s_sts_ready, s2mm_sts_ready}), 128'(3));

        // READ, OKAY status
        exp_cmpl(4'd0, 4'h8, 23'd256);
        send_req(2'b00, 32'h1000_0000, 32'h0, 23'd256, 4'd0);
        tick();
        send_sts(1'b0, 8'h80);
        drain();
        chk("read_bytes", 128'(bytes_done), 128'(256));
        chk("read_cmds", 128'(cmds_done), 128'(1));

        // COPY, S2MM status first
        s2mm_tready = 1'b0;
        send_req(2'b10, 32'h0000_2000, 32'h0000_3000, 23'd64, 4'd1);
        tick();
        chk("copy_s2mm_held", 128'(s2mm_tvalid), 128'(1));
        chk("copy_busy_not_ready", 128'(req_ready), 128'(0));
        s2mm_tready = 1'b1;
        tick();
        tick();
        send_sts(1'b1, 8'h81);
        tick();
        tick();
        chk("copy_wait_second_sts", 128'(cmpl_valid), 128'(0));
        exp_cmpl(4'd1, 4'h8, 23'd64);
        send_sts(1'b0, 8'h81);
        drain();
        chk("copy_bytes_once", 128'(bytes_done), 128'(320));

        // Fill the table, first issue stalled by tready
        mm2s_tready = 1'b0;
        send_req(2'b00, 32'h0000_5000, 32'h0, 23'd16, 4'd2);
        tick();
        chk("stall_not_ready", 128'(req_ready), 128'(0));
        mm2s_tready = 1'b1;
        send_req(2'b00, 32'h0000_5100, 32'h0, 23'd16, 4'd3);
        send_req(2'b00, 32'h0000_5200, 32'h0, 23'd16, 4'd4);
        send_req(2'b00, 32'h0000_5300, 32'h0, 23'd16, 4'd5);
        tick();
        tick();
        chk("full_not_ready", 128'(req_ready), 128'(0));
        chk("full_outstanding", 128'(outstanding), 128'(4));
        send_sts(1'b0, 8'h83);
        tick();
        chk("head_blocks_retire", 128'(cmpl_valid), 128'(0));
        exp_cmpl(4'd2, 4'h8, 23'd16);
        exp_cmpl(4'd3, 4'h8, 23'd16);
        send_sts(1'b0, 8'h82);
        chk("full_until_retire", 128'(req_ready), 128'(0));
        tick();
        chk("ready_after_retire", 128'(req_ready), 128'(1));
        exp_cmpl(4'd4, 4'h4, 23'd16);
        exp_cmpl(4'd5, 4'h8, 23'd16);
        send_sts(1'b0, 8'h85);
        send_sts(1'b0, 8'hC4);
        drain();
        chk("fill_bytes", 128'(bytes_done), 128'(368));
        chk("fill_cmds", 128'(cmds_done), 128'(6));

        // WRITE with DECERR
        exp_cmpl(4'd6, 4'h2, 23'd100);
        send_req(2'b01, 32'h0, 32'h4000_0000, 23'd100, 4'd6);
        tick();
        send_sts(1'b1, 8'h26);
        drain();
        chk("decerr_bytes", 128'(bytes_done), 128'(368));
        chk("decerr_cmds", 128'(cmds_done), 128'(7));

        // Illegal requests: reserved op, then zero BTT
        exp_cmpl(4'd7, 4'h1, 23'd5);
        send_req(2'b11, 32'h0000_9000, 32'h0000_A000, 23'd5, 4'd7);
        chk("illegal_cmpl_latency", 128'(cmpl_valid), 128'(1));
        chk("illegal_no_cmd", 128'({mm2s_tvalid, s2mm_tvalid}), 128'(0));
        exp_cmpl(4'd8, 4'h1, 23'd0);
        send_req(2'b00, 32'h0000_9100, 32'h0, 23'd0, 4'd8);
        chk("zero_btt_head_tag", 128'(cmpl_tag), 128'(8));
        chk("accept_retire_same_cycle", 128'(outstanding), 128'(1));
        drain();
        chk("illegal_tag_err_clear", 128'(tag_err), 128'(0));
        send_sts(1'b0, 8'h87);
        chk("tag_err_not_pending", 128'(tag_err), 128'(1));

        // COPY with both statuses in one cycle
        exp_cmpl(4'd9, 4'h1, 23'd32);
        send_req(2'b10, 32'h0000_6000, 32'h0000_7000, 23'd32, 4'd9);
        tick();
        tick();
        mm2s_sts = 8'h89;
        s2mm_sts = 8'h99;
        mm2s_sts_valid = 1'b1;
        s2mm_sts_valid = 1'b1;
        tick();
        mm2s_sts_valid = 1'b0;
        s2mm_sts_valid = 1'b0;
        drain();
        chk("dual_sts_cmds", 128'(cmds_done), 128'(10));
        chk("tag_err_sticky", 128'(tag_err), 128'(1));

        // Completion held, then async reset mid-issue
        cmpl_ready = 1'b0;
        send_req(2'b11, 32'h0, 32'h0, 23'd1, 4'd10);
        tick();
        tick();
        chk("cmpl_held_valid", 128'(cmpl_valid), 128'(1));
        chk("cmpl_held_tag", 128'(cmpl_tag), 128'(10));
        s2mm_tready = 1'b0;
        send_req(2'b01, 32'h0, 32'h0000_8000, 23'd8, 4'd11);
        chk("pre_reset_tvalid", 128'(s2mm_tvalid), 128'(1));
        chk("pre_reset_outstanding", 128'(outstanding), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", 128'(s2mm_tvalid), 128'(0));
        chk("async_rst_outstanding", 128'(outstanding), 128'(0));
        chk("async_rst_cmpl_valid", 128'(cmpl_valid), 128'(0));
        q_mm2s.delete();
        q_s2mm.delete();
        q_cmpl.delete();
        m_bytes = '0;
        m_cmds  = '0;
        tick();
        rst_n = 1'b1;
        cmpl_ready = 1'b1;
        s2mm_tready = 1'b1;
        chk("post_rst_counters", 128'({bytes_done, cmds_done, tag_err}), 128'(0));
        tick();
        send_sts(1'b1, 8'h8B);
        chk("stale_sts_tag_err", 128'(tag_err), 128'(1));

        // Tag counter restarts at 0
        exp_cmpl(4'd0, 4'h8, 23'd4);
        send_req(2'b00, 32'h0000_0040, 32'h0, 23'd4, 4'd0);
        tick();
        send_sts(1'b0, 8'h80);
        drain();
        chk("post_rst_bytes", 128'(bytes_done), 128'(4));
        chk("post_rst_cmds", 128'(cmds_done), 128'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
